kbd_fifo: RTL and testbench
===========================

Name: kbd_fifo

Overview:
- Keyboard buffer stage between the PS/2 receiver (`ps2_data`/`ps2_hit`) and the CPU port space.
- Queues received scancodes and presents them on I/O ports 0x60 (data), 0x64 (status/command) and 0x61 (XT-style acknowledge).
- Raises the IRQ1 request line toward the interrupt logic while data is pending.
- Isolates the CPU from scancode bursts so no byte is lost while an interrupt handler is busy.

Parameters:
- DEPTH, 16, FIFO entries (power of two, 2..256).
- AW, 4, pointer width = log2(DEPTH).

Ports:
- clock  input  1  single block clock; all inputs synchronous to it.
- resetn  input  1  asynchronous active-low reset.
- ps2_data  input  8  received scancode, valid while ps2_hit is high.
- ps2_hit  input  1  receive flag; may stay high several cycles; one byte per rising edge.
- io_addr  input  16  CPU port address.
- io_rd  input  1  one-cycle port read strobe.
- io_wr  input  1  one-cycle port write strobe.
- io_din  input  8  CPU write data.
- io_dout  output  8  registered read data.
- io_sel  output  1  registered; high the cycle after a read hit on 0x60/0x61/0x64.
- irq1  output  1  level interrupt request.
- kb_enabled  output  1  keyboard enable state (debug/LED).

Behaviour:
- Reset values: all pointers/count 0; `io_dout` 0x00; `io_sel` 0; `irq1` 0; `kb_enabled` 1; overflow 0; `prev_hit` 0; `port61` 0x00; `gap` 0.
- Push:
  - Condition: `ps2_hit` & !`prev_hit` & `kb_enabled`.
  - `ps2_data` is written at the tail.
  - Full and no simultaneous pop: byte dropped, sticky overflow set.
  - Full with a simultaneous pop: push accepted.
  - Disabled: byte dropped silently, overflow unchanged.
- Read 0x60:
  - `io_dout` <= head byte, or the last value held in `io_dout` if empty.
  - Pops when non-empty.
  - Push and read in the same cycle on an empty FIFO: read returns the stale value, the push is stored, count ends at 1.
- Read 0x64: `io_dout` <= {1'b0, 1'b0, ovf, 1'b1, 1'b0, 1'b1, 1'b0, !empty}.
  - Bit0 = output buffer full; bit2 = system flag; bit4 = inhibit-off; bit5 = overflow.
  - Overflow clears on this read; an overflow event in the same cycle wins and stays set.
- Read 0x61: `io_dout` <= `port61`.
- Other addresses: `io_sel` 0 and `io_dout` holds.
- Write 0x61:
  - `port61` <= `io_din`.
  - A 0->1 transition of bit7 pops one entry if non-empty (XT acknowledge).
  - Bit7 already 1: no pop.
- Write 0x64 commands:
  - 0xAD: `kb_enabled` <= 0.
  - 0xAE: `kb_enabled` <= 1.
  - 0xFF: flush FIFO (pointers 0, overflow 0), same cycle as decode; a simultaneous push is discarded.
  - Other values ignored.
- Write 0x60: ignored.
- `irq1` (registered):
  - `irq1` <= !empty_next & !`gap`.
  - `gap` is set for exactly one cycle after any pop that leaves the FIFO non-empty, so an edge-triggered PIC sees a fresh rising edge per byte.
- Latencies:
  - `irq1` rises 2 cycles after the `ps2_hit` rising edge (edge register, then irq register).
  - `io_dout`/`io_sel` valid 1 cycle after `io_rd`.
- Pointers wrap modulo DEPTH; count is AW+1 bits; full = count==DEPTH.
- `resetn` low mid-operation clears the queue immediately; there are no partial-state requirements.

Decomposition:
- Shared package `kbd_pkg`:
  - Port constants `KBD_DATA`=16'h0060, `KBD_PB`=16'h0061, `KBD_STAT`=16'h0064.
  - Command constants `CMD_DIS`=8'hAD, `CMD_ENA`=8'hAE, `CMD_FLUSH`=8'hFF.
  - Status bit indices.
- Sub-module `sync_fifo` (DEPTH/AW parameterised, push/pop/flush, full/empty/count, registered head).
- The top handles edge detect, port decode, the status register and the irq/gap logic.

Test Plan:
- Push 0x1C via one 3-cycle `ps2_hit` pulse -> exactly one entry; `irq1`=1 two cycles later; read 0x64 gives 0x15; read 0x60 gives 0x1C; `irq1` falls; status then 0x14.
- Push 0x1C, 0xF0, 0x1C, then three reads of 0x60 -> data in order; `irq1` drops for one cycle between reads; ends at 0.
- Push 17 bytes 0x01..0x11 with DEPTH=16 -> 0x64 read gives 0x35 (overflow set); the following 0x64 read gives 0x15; sixteen 0x60 reads return 0x01..0x10.
- Write 0x64 <= 0xAD, push 0x2A -> FIFO stays empty, `irq1` 0, `kb_enabled` 0; write 0xAE, push 0x2A -> accepted.
- Queue 2 bytes, write 0x61 <= 0x00, then 0x80, then 0x80 -> one pop only; 0x61 read gives 0x80.
- Queue 5 bytes, write 0x64 <= 0xFF in the same cycle as a push -> empty, `irq1` 0, overflow 0; assert `resetn` mid-stream -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared constants for the keyboard buffer stage.
// Port addresses, controller command bytes and status register bit positions,
// plus a helper that assembles the 0x64 status byte.
package kbd_pkg;

   localparam logic [15:0] KBD_DATA  = 16'h0060;
   localparam logic [15:0] KBD_PB    = 16'h0061;
   localparam logic [15:0] KBD_STAT  = 16'h0064;

   localparam logic [7:0]  CMD_DIS   = 8'hAD;
   localparam logic [7:0]  CMD_ENA   = 8'hAE;
   localparam logic [7:0]  CMD_FLUSH = 8'hFF;

   // Status register bit positions
   localparam int ST_OBF = 0;   // output buffer full
   localparam int ST_SYS = 2;   // system flag, always 1
   localparam int ST_INH = 4;   // inhibit switch off, always 1
   localparam int ST_OVF = 5;   // sticky receive overflow

   function automatic logic [7:0] status_byte(input logic ovf, input logic not_empty);
      logic [7:0] s;
      s         = 8'h00;
      s[ST_OBF] = not_empty;
      s[ST_SYS] = 1'b1;
      s[ST_INH] = 1'b1;
      s[ST_OVF] = ovf;
      return s;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous byte FIFO with first-word-fall-through head.
// Ports:
//   clock, resetn       clock and asynchronous active-low reset
//   push_i, data_i      write request and byte
//   pop_i               read request (ignored when empty)
//   flush_i             clear pointers/count; overrides push and pop
//   head_o              byte at the head of the queue
//   empty_o, full_o     occupancy flags for the current cycle
//   count_next_o        occupancy after this cycle's push/pop/flush
module sync_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          push_i,
   input  logic [7:0]    data_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output logic [7:0]    head_o,
   output logic          empty_o,
   output logic          full_o,
   output logic [AW:0]   count_next_o
);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          wr_en, rd_en;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign head_o  = mem_q[rd_ptr_q];

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
   // when it is also being read.
   assign rd_en = pop_i && !empty_o && !flush_i;
   assign wr_en = push_i && (!full_o || rd_en) && !flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
         if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   assign count_next_o = count_d;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset so it maps onto RAM; contents are only
   // observable through the pointers, which are reset.
   always_ff @(posedge clock) begin
      if (wr_en) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/kbd_fifo.sv
// Keyboard buffer stage: queues PS/2 scancodes and serves them on ports
// 0x60 (data), 0x64 (status/command) and 0x61 (XT acknowledge), with IRQ1.
// Ports:
//   clock, resetn         clock and asynchronous active-low reset
//   ps2_data, ps2_hit     received byte and receive flag (one byte per rising edge)
//   io_addr, io_rd, io_wr, io_din   CPU port access
//   io_dout, io_sel       registered read data and read-hit flag
//   irq1                  level interrupt request
//   kb_enabled            keyboard enable state
module kbd_fifo
   import kbd_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [7:0]  ps2_data,
   input  logic        ps2_hit,
   input  logic [15:0] io_addr,
   input  logic        io_rd,
   input  logic        io_wr,
   input  logic [7:0]  io_din,
   output logic [7:0]  io_dout,
   output logic        io_sel,
   output logic        irq1,
   output logic        kb_enabled
);

   logic       prev_hit_q, prev_hit_d;
   logic       push_q, push_d;
   logic [7:0] push_data_q, push_data_d;
   logic       kb_en_q, kb_en_d;
   logic       ovf_q, ovf_d;
   logic [7:0] port61_q, port61_d;
   logic       gap_q, gap_d;
   logic       irq1_q, irq1_d;
   logic [7:0] dout_q, dout_d;
   logic       sel_q, sel_d;

   logic       rd_data, rd_pb, rd_stat, wr_pb, wr_stat;
   logic       flush, ack, pop_req, ovf_evt, empty_next;
   logic       fifo_empty, fifo_full;
   logic [7:0] fifo_head;
   logic [AW:0] count_next;

   assign rd_data = io_rd && (io_addr == KBD_DATA);
   assign rd_pb   = io_rd && (io_addr == KBD_PB);
   assign rd_stat = io_rd && (io_addr == KBD_STAT);
   assign wr_pb   = io_wr && (io_addr == KBD_PB);
   assign wr_stat = io_wr && (io_addr == KBD_STAT);

   assign flush   = wr_stat && (io_din == CMD_FLUSH);
   // XT acknowledge: only a 0->1 edge of port 0x61 bit 7 consumes a byte.
   assign ack     = wr_pb && io_din[7] && !port61_q[7];
   assign pop_req = (rd_data || ack) && !fifo_empty;
   assign ovf_evt = push_q && fifo_full && !pop_req && !flush;
   assign empty_next = (count_next == '0);

   sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clock        (clock),
      .resetn       (resetn),
      .push_i       (push_q),
      .data_i       (push_data_q),
      .pop_i        (pop_req),
      .flush_i      (flush),
      .head_o       (fifo_head),
      .empty_o      (fifo_empty),
      .full_o       (fifo_full),
      .count_next_o (count_next)
   );

   always_comb begin
      prev_hit_d  = ps2_hit;
      push_d      = ps2_hit && !prev_hit_q && kb_en_q;
      push_data_d = push_data_q;
      kb_en_d     = kb_en_q;
      ovf_d       = ovf_q;
      port61_d    = port61_q;
      dout_d      = dout_q;
      sel_d       = rd_data || rd_pb || rd_stat;

      if (push_d) push_data_d = ps2_data;

      if (wr_stat && io_din == CMD_DIS) kb_en_d = 1'b0;
      if (wr_stat && io_din == CMD_ENA) kb_en_d = 1'b1;
      if (wr_pb) port61_d = io_din;

      // Flush clears everything; a fresh overflow beats the clear-on-read.
      if (flush)        ovf_d = 1'b0;
      else if (ovf_evt) ovf_d = 1'b1;
      else if (rd_stat) ovf_d = 1'b0;

      if (rd_data && !fifo_empty) dout_d = fifo_head;
      else if (rd_stat)           dout_d = status_byte(ovf_q, !fifo_empty);
      else if (rd_pb)             dout_d = port61_q;

      // Drop the request for a cycle after each pop that leaves data behind,
      // giving an edge-triggered PIC a new rising edge per byte.
      gap_d  = pop_req && !empty_next;
      irq1_d = !empty_next && !gap_q;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         prev_hit_q  <= 1'b0;
         push_q      <= 1'b0;
         push_data_q <= 8'h00;
         kb_en_q     <= 1'b1;
         ovf_q       <= 1'b0;
         port61_q    <= 8'h00;
         gap_q       <= 1'b0;
         irq1_q      <= 1'b0;
         dout_q      <= 8'h00;
         sel_q       <= 1'b0;
      end else begin
         prev_hit_q  <= prev_hit_d;
         push_q      <= push_d;
         push_data_q <= push_data_d;
         kb_en_q     <= kb_en_d;
         ovf_q       <= ovf_d;
         port61_q    <= port61_d;
         gap_q       <= gap_d;
         irq1_q      <= irq1_d;
         dout_q      <= dout_d;
         sel_q       <= sel_d;
      end
   end

   assign io_dout    = dout_q;
   assign io_sel     = sel_q;
   assign irq1       = irq1_q;
   assign kb_enabled = kb_en_q;

endmodule

// File: tb/tb_kbd_fifo.sv
module tb_kbd_fifo;

   logic        clock, resetn;
   logic [7:0]  ps2_data;
   logic        ps2_hit;
   logic [15:0] io_addr;
   logic        io_rd, io_wr;
   logic [7:0]  io_din;
   logic [7:0]  io_dout;
   logic        io_sel, irq1, kb_enabled;

   kbd_fifo #(.DEPTH(16), .AW(4)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .ps2_data   (ps2_data),
      .ps2_hit    (ps2_hit),
      .io_addr    (io_addr),
      .io_rd      (io_rd),
      .io_wr      (io_wr),
      .io_din     (io_din),
      .io_dout    (io_dout),
      .io_sel     (io_sel),
      .irq1       (irq1),
      .kb_enabled (kb_enabled)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int n_vec  = 0;
   int n_fail = 0;

   // Reference model: a byte queue plus the visible controller state.
   logic [7:0] q[$];
   logic [7:0] m_dout, m_pdata, m_p61;
   logic       m_sel, m_irq, m_en, m_ovf, m_gap, m_prev, m_pend;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_dout = 8'h00; m_pdata = 8'h00; m_p61 = 8'h00;
      m_sel = 0; m_irq = 0; m_en = 1; m_ovf = 0; m_gap = 0; m_prev = 0; m_pend = 0;
   endtask

   task automatic model_step(input logic hit, input logic [7:0] d, input logic rd, input logic wr,
                             input logic [15:0] a, input logic [7:0] din);
      logic r60, r61, r64, w61, w64, flush, ack, do_pop, evt;
      logic [7:0] st;
      int sz;
      r60 = rd && a == 16'h0060; r61 = rd && a == 16'h0061; r64 = rd && a == 16'h0064;
      w61 = wr && a == 16'h0061; w64 = wr && a == 16'h0064;
      sz  = q.size();
      st  = {2'b00, m_ovf, 1'b1, 1'b0, 1'b1, 1'b0, sz != 0};
      flush  = w64 && din == 8'hFF;
      ack    = w61 && din[7] && !m_p61[7];
      do_pop = (r60 || ack) && sz > 0;
      m_sel  = r60 || r61 || r64;
      if (r60 && sz > 0) m_dout = q[0];
      else if (r64)      m_dout = st;
      else if (r61)      m_dout = m_p61;
      if (do_pop) void'(q.pop_front());
      evt = 0;
      if (flush) q.delete();
      else if (m_pend) begin
         if (q.size() < 16) q.push_back(m_pdata);
         else evt = 1;
      end
      if (flush) m_ovf = 0; else if (evt) m_ovf = 1; else if (r64) m_ovf = 0;
      m_irq = (q.size() != 0) && !m_gap;
      m_gap = do_pop && (q.size() != 0);
      if (w61) m_p61 = din;
      m_pend  = hit && !m_prev && m_en;
      m_pdata = d;
      m_prev  = hit;
      if (w64 && din == 8'hAD) m_en = 0;
      if (w64 && din == 8'hAE) m_en = 1;
   endtask

   // One clock cycle: drive, clock, advance the model, compare just after the edge.
   task automatic cyc(input logic hit, input logic [7:0] d, input logic rd, input logic wr,
                      input logic [15:0] a, input logic [7:0] din);
      ps2_hit = hit; ps2_data = d; io_rd = rd; io_wr = wr; io_addr = a; io_din = din;
      @(posedge clock);
      model_step(hit, d, rd, wr, a, din);
      #1;
      check("dout", io_dout, m_dout);
      check("sel", {7'b0, io_sel}, {7'b0, m_sel});
      check("irq1", {7'b0, irq1}, {7'b0, m_irq});
      check("kb_en", {7'b0, kb_enabled}, {7'b0, m_en});
   endtask

   task automatic idle();                  cyc(0, 8'h00, 0, 0, 16'h0000, 8'h00); endtask
   task automatic push_byte(input logic [7:0] d); cyc(1, d, 0, 0, 16'h0000, 8'h00); idle(); endtask
   task automatic rd_port(input logic [15:0] a);  cyc(0, 8'h00, 1, 0, a, 8'h00); endtask
   task automatic wr_port(input logic [15:0] a, input logic [7:0] v); cyc(0, 8'h00, 0, 1, a, v); endtask

   typedef struct {
      logic        hit;
      logic [7:0]  data;
      logic        rd;
      logic [15:0] addr;
      logic [7:0]  exp_dout;
      logic        exp_sel;
      logic        exp_irq;
   } vec_t;

   vec_t tbl[7];

   initial begin
      resetn = 0; ps2_hit = 0; ps2_data = 0; io_addr = 0; io_rd = 0; io_wr = 0; io_din = 0;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      check("rst_dout", io_dout, 8'h00);
      check("rst_sel", {7'b0, io_sel}, 8'h00);
      check("rst_irq", {7'b0, irq1}, 8'h00);
      check("rst_kben", {7'b0, kb_enabled}, 8'h01);
      resetn = 1;

      // Single byte via a 3-cycle hit pulse; irq two cycles after the edge.
      tbl[0] = '{1, 8'h1C, 0, 16'h0000, 8'h00, 0, 0};
      tbl[1] = '{1, 8'h1C, 0, 16'h0000, 8'h00, 0, 1};
      tbl[2] = '{1, 8'h1C, 0, 16'h0000, 8'h00, 0, 1};
      tbl[3] = '{0, 8'h00, 1, 16'h0064, 8'h15, 1, 1};
      tbl[4] = '{0, 8'h00, 1, 16'h0060, 8'h1C, 1, 0};
      tbl[5] = '{0, 8'h00, 1, 16'h0064, 8'h14, 1, 0};
      tbl[6] = '{0, 8'h00, 0, 16'h0000, 8'h14, 0, 0};
      for (int i = 0; i < 7; i++) begin
         cyc(tbl[i].hit, tbl[i].data, tbl[i].rd, 0, tbl[i].addr, 8'h00);
         check($sformatf("tbl%0d_dout", i), io_dout, tbl[i].exp_dout);
         check($sformatf("tbl%0d_sel", i), {7'b0, io_sel}, {7'b0, tbl[i].exp_sel});
         check($sformatf("tbl%0d_irq", i), {7'b0, irq1}, {7'b0, tbl[i].exp_irq});
      end

      // Three bytes read back in order, irq gapping between reads.
      push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h1C); idle();
      rd_port(16'h0060); check("seq_b0", io_dout, 8'h1C); idle(); idle();
      rd_port(16'h0060); check("seq_b1", io_dout, 8'hF0); idle(); idle();
      rd_port(16'h0060); check("seq_b2", io_dout, 8'h1C); idle(); idle();
      check("seq_irq_end", {7'b0, irq1}, 8'h00);

      // Overflow on the 17th byte, cleared by one status read.
      for (int i = 1; i <= 17; i++) push_byte(8'(i));
      rd_port(16'h0064); check("ovf_stat", io_dout, 8'h35);
      rd_port(16'h0064); check("ovf_clr", io_dout, 8'h15);
      for (int i = 1; i <= 16; i++) begin
         rd_port(16'h0060); check($sformatf("ovf_rd%0d", i), io_dout, 8'(i));
      end
      rd_port(16'h0060); check("empty_stale", io_dout, 8'h10);

      // Disable drops bytes, enable resumes.
      wr_port(16'h0064, 8'hAD); push_byte(8'h2A); idle();
      check("dis_kben", {7'b0, kb_enabled}, 8'h00);
      check("dis_irq", {7'b0, irq1}, 8'h00);
      rd_port(16'h0064); check("dis_stat", io_dout, 8'h14);
      wr_port(16'h0064, 8'hAE); push_byte(8'h2A); idle();
      rd_port(16'h0060); check("ena_rd", io_dout, 8'h2A);

      // XT acknowledge pops only on a rising bit 7.
      push_byte(8'h01); push_byte(8'h02);
      wr_port(16'h0061, 8'h00); wr_port(16'h0061, 8'h80); wr_port(16'h0061, 8'h80);
      rd_port(16'h0064); check("xt_stat", io_dout, 8'h15);
      rd_port(16'h0061); check("xt_p61", io_dout, 8'h80);
      rd_port(16'h0060); check("xt_rd", io_dout, 8'h02);

      // Full FIFO accepts a push that coincides with a pop.
      for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
      cyc(1, 8'hAA, 0, 0, 16'h0000, 8'h00);
      cyc(0, 8'h00, 1, 0, 16'h0060, 8'h00); check("fullpop_rd", io_dout, 8'h40);
      rd_port(16'h0064); check("fullpop_stat", io_dout, 8'h15);
      for (int i = 0; i < 16; i++) rd_port(16'h0060);
      check("fullpop_last", io_dout, 8'hAA);

      // Flush with a simultaneous push.
      for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i));
      cyc(1, 8'h77, 0, 0, 16'h0000, 8'h00);
      wr_port(16'h0064, 8'hFF); idle();
      check("flush_irq", {7'b0, irq1}, 8'h00);
      rd_port(16'h0064); check("flush_stat", io_dout, 8'h14);

      // Asynchronous reset mid-stream.
      push_byte(8'h11); push_byte(8'h22); rd_port(16'h0064);
      resetn = 0;
      #2;
      check("arst_dout", io_dout, 8'h00);
      check("arst_sel", {7'b0, io_sel}, 8'h00);
      check("arst_irq", {7'b0, irq1}, 8'h00);
      check("arst_kben", {7'b0, kb_enabled}, 8'h01);
      model_reset();
      ps2_hit = 0; io_rd = 0; io_wr = 0;
      @(posedge clock); #2; resetn = 1;
      rd_port(16'h0064); check("arst_stat", io_dout, 8'h14);

      // Randomised traffic against the model.
      begin
         logic hit, rd, wr;
         logic [15:0] a;
         logic [7:0] din;
         logic [15:0] raddr[5];
         logic [7:0]  cmds[6];
         raddr = '{16'h0060, 16'h0060, 16'h0064, 16'h0061, 16'h0065};
         cmds  = '{8'hAE, 8'hAE, 8'hAD, 8'hFF, 8'h12, 8'hAE};
         hit = 0;
         for (int n = 0; n < 3000; n++) begin
            if (hit) hit = ($urandom_range(0, 1) == 0);
            else     hit = ($urandom_range(0, 9) < 4);
            rd = ($urandom_range(0, 9) < 2);
            wr = ($urandom_range(0, 19) == 0);
            din = 8'($urandom);
            if (wr) begin
               case ($urandom_range(0, 2))
                  0: a = 16'h0061;
                  1: begin a = 16'h0064; din = cmds[$urandom_range(0, 5)]; end
                  default: a = 16'h0060;
               endcase
            end else begin
               a = raddr[$urandom_range(0, 4)];
            end
            cyc(hit, 8'($urandom), rd, wr, a, din);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
